// File: rtl/l2_pkg.sv
// Shared types, constants and PLRU helpers for the L2 way controller.
package l2_pkg;

  localparam int WAYS      = 4;
  localparam int PLRU_BITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM    = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Tree PLRU victim: b0 picks the pair, b1/b2 pick within the pair.
  function automatic logic [1:0] plru_victim(input logic [PLRU_BITS-1:0] plru);
    logic [1:0] way;
    if (!plru[0]) way = plru[1] ? 2'd1 : 2'd0;
    else          way = plru[2] ? 2'd3 : 2'd2;
    return way;
  endfunction

  // Point the tree away from the way just accessed; untouched bits keep their value.
  function automatic logic [PLRU_BITS-1:0] plru_update(input logic [PLRU_BITS-1:0] plru,
                                                       input logic [1:0]           way);
    logic [PLRU_BITS-1:0] nxt;
    nxt = plru;
    case (way)
      2'd0: begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
      2'd1: begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
      2'd2: begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
      default: begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/l2_tag_store.sv
// Per-set tag, valid and PLRU storage: combinational read, single write port.
// A fill writes tag + valid + PLRU; a hit update writes PLRU only.
module l2_tag_store
  import l2_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 14
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [INDEX_BITS-1:0]             index,
  output logic [WAYS-1:0][TAG_BITS-1:0]     rd_tag,
  output logic [WAYS-1:0]                   rd_valid,
  output logic [PLRU_BITS-1:0]              rd_plru,
  input  logic                              wr_en,
  input  logic                              wr_fill,
  input  logic [1:0]                        wr_way,
  input  logic [TAG_BITS-1:0]               wr_tag,
  input  logic [PLRU_BITS-1:0]              wr_plru
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [WAYS-1:0][TAG_BITS-1:0] tag_mem   [SETS];
  logic [WAYS-1:0]               valid_mem [SETS];
  logic [PLRU_BITS-1:0]          plru_mem  [SETS];

  assign rd_tag   = tag_mem[index];
  assign rd_valid = valid_mem[index];
  assign rd_plru  = plru_mem[index];

  // Valid and PLRU state clear asynchronously so a reset never leaves a half-filled line valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        valid_mem[i] <= '0;
        plru_mem[i]  <= '0;
      end
    end else if (wr_en) begin
      plru_mem[index] <= wr_plru;
      if (wr_fill) valid_mem[index][wr_way] <= 1'b1;
    end
  end

  // Tags need no reset: they are only ever read through a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en && wr_fill) tag_mem[index][wr_way] <= wr_tag;
  end

endmodule

// File: rtl/l2_way_controller.sv
// Sequencing controller for a 4-way set-associative L2 bank.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the requester holds req_valid/req_write/req_addr stable until then.
// mem_req is held until the cycle mem_ack is seen; fill data is valid in that cycle.
module l2_way_controller
  import l2_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [TAG_BITS+INDEX_BITS-1:0] req_addr,
  output logic [INDEX_BITS-1:0]          way_index,
  output logic [WAYS-1:0]                way_re,
  output logic [WAYS-1:0]                way_we,
  output logic                           way_fill,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [1:0]                     resp_way,
  output logic                           mem_req,
  output logic                           mem_write,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_addr,
  input  logic                           mem_ack,
  output state_t                         debug_state
);

  localparam int ADDR_BITS = TAG_BITS + INDEX_BITS;

  state_t                         state, state_next;
  logic [ADDR_BITS-1:0]           addr_q;
  logic                           write_q;
  logic                           hit_q;
  logic [1:0]                     way_q;

  logic [WAYS-1:0][TAG_BITS-1:0]  rd_tag;
  logic [WAYS-1:0]                rd_valid;
  logic [PLRU_BITS-1:0]           rd_plru;
  logic                           hit;
  logic [1:0]                     hit_way;
  logic [1:0]                     victim;
  logic                           ts_wr_en;
  logic                           ts_wr_fill;
  logic [1:0]                     ts_wr_way;
  logic [PLRU_BITS-1:0]           ts_wr_plru;
  logic [TAG_BITS-1:0]            tag_q;

  assign tag_q = addr_q[ADDR_BITS-1:INDEX_BITS];

  l2_tag_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_tag_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .index    (addr_q[INDEX_BITS-1:0]),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_plru  (rd_plru),
    .wr_en    (ts_wr_en),
    .wr_fill  (ts_wr_fill),
    .wr_way   (ts_wr_way),
    .wr_tag   (tag_q),
    .wr_plru  (ts_wr_plru)
  );

  // Tag compare over valid ways only; at most one can match.
  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_valid[w] && rd_tag[w] == tag_q) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the PLRU choice.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = plru_victim(rd_plru);
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !rd_valid[w]) begin
        victim = 2'(w);
        found  = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, way strobes and tag-store writes.
  always_comb begin
    state_next = state;
    way_re     = '0;
    way_we     = '0;
    way_fill   = 1'b0;
    ts_wr_en   = 1'b0;
    ts_wr_fill = 1'b0;
    ts_wr_way  = 2'd0;
    ts_wr_plru = rd_plru;
    case (state)
      IDLE: begin
        if (req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          ts_wr_en   = 1'b1;
          ts_wr_plru = plru_update(rd_plru, hit_way);
          if (write_q) begin
            way_we     = WAYS'(1) << hit_way;
            state_next = MEM;
          end else begin
            way_re     = WAYS'(1) << hit_way;
            state_next = RESP;
          end
        end else begin
          state_next = MEM;
        end
      end
      MEM: begin
        if (mem_ack) begin
          if (!write_q && !hit_q) begin
            way_we     = WAYS'(1) << way_q;
            way_fill   = 1'b1;
            ts_wr_en   = 1'b1;
            ts_wr_fill = 1'b1;
            ts_wr_way  = way_q;
            ts_wr_plru = plru_update(rd_plru, way_q);
          end
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch and lookup result (hit flag and hit/victim way).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      way_q   <= 2'd0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        write_q <= req_write;
      end
      if (state == LOOKUP) begin
        hit_q <= hit;
        way_q <= hit ? hit_way : (write_q ? 2'd0 : victim);
      end
    end
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign resp_hit    = (state == RESP) && hit_q;
  assign resp_way    = (state == RESP) ? way_q : 2'd0;
  assign mem_req     = (state == MEM);
  assign mem_write   = (state == MEM) && write_q;
  assign mem_addr    = (state == MEM) ? addr_q : '0;
  assign way_index   = addr_q[INDEX_BITS-1:0];
  assign debug_state = state;

endmodule

// File: tb/tb_l2_way_controller.sv
// Directed plus randomized bench for l2_way_controller with a set/way reference model.
module tb_l2_way_controller;
  import l2_pkg::*;

  localparam int IB = 6;
  localparam int TB = 14;
  localparam int AB = IB + TB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AB-1:0] req_addr = '0;
  logic [IB-1:0] way_index;
  logic [3:0]    way_re, way_we;
  logic          way_fill, resp_valid, resp_hit, mem_req, mem_write;
  logic [1:0]    resp_way;
  logic [AB-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  state_t        debug_state;

  l2_way_controller #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .way_index   (way_index),
    .way_re      (way_re),
    .way_we      (way_we),
    .way_fill    (way_fill),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_way    (resp_way),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .debug_state (debug_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];   // expected {hit, way} per request

  logic [TB-1:0] m_tag   [64][4];
  bit            m_valid [64][4];
  bit            m_b0 [64];
  bit            m_b1 [64];
  bit            m_b2 [64];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      m_b0[s] = 1'b0; m_b1[s] = 1'b0; m_b2[s] = 1'b0;
    end
  endfunction

  function automatic void m_touch(input int s, input int w);
    if (w < 2) begin m_b0[s] = 1'b1; m_b1[s] = (w == 0); end
    else       begin m_b0[s] = 1'b0; m_b2[s] = (w == 2); end
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    if (!m_b0[s]) return m_b1[s] ? 1 : 0;
    return m_b2[s] ? 3 : 2;
  endfunction

  function automatic int m_lookup(input int s, input logic [TB-1:0] t);
    for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input bit wr, input logic [AB-1:0] addr, input int ack_wait, input bit hold);
    int            s, hw, v, rw;
    logic [TB-1:0] t;
    bit            hit, need_mem;
    logic [3:0]    exp_re, exp_we, exp_fill;
    logic [2:0]    exp;
    s        = int'(addr[IB-1:0]);
    t        = addr[AB-1:IB];
    hw       = m_lookup(s, t);
    hit      = (hw >= 0);
    v        = m_victim(s);
    need_mem = wr || !hit;
    exp_re   = (!wr && hit) ? 4'(1 << hw) : 4'd0;
    exp_we   = (wr && hit)  ? 4'(1 << hw) : 4'd0;
    exp_fill = (!wr && !hit) ? 4'(1 << v) : 4'd0;
    rw       = hit ? hw : (wr ? 0 : v);
    exp_q.push_back({hit, 2'(rw)});

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    #1 check("accept_ready", req_ready, 1);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    #1;
    check("lookup_state", debug_state, LOOKUP);
    check("lookup_index", way_index, s);
    check("lookup_re", way_re, exp_re);
    check("lookup_we", way_we, exp_we);
    check("lookup_ready", req_ready, 0);
    check("lookup_memreq", mem_req, 0);
    if (need_mem) begin
      @(negedge clk); #1;
      check("mem_req", mem_req, 1);
      check("mem_write", mem_write, wr);
      check("mem_addr", mem_addr, addr);
      check("mem_we_idle", way_we, 0);
      for (int i = 0; i < ack_wait; i++) begin
        @(negedge clk); #1;
        check("mem_req_hold", mem_req, 1);
        check("mem_ready_hold", req_ready, 0);
      end
      mem_ack = 1'b1;
      #1;
      check("ack_we", way_we, exp_fill);
      check("ack_fill", way_fill, (exp_fill != 0));
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
    end else begin
      @(negedge clk); #1;
    end
    exp = exp_q.pop_front();
    check("resp_valid", resp_valid, 1);
    check("resp_hit", resp_hit, exp[2]);
    check("resp_way", resp_way, exp[1:0]);
    check("resp_ready", req_ready, 0);
    check("resp_memreq", mem_req, 0);
    if (hold) req_valid = 1'b0;

    if (hit) m_touch(s, hw);
    else if (!wr) begin
      m_tag[s][v] = t; m_valid[s][v] = 1'b1; m_touch(s, v);
    end

    @(negedge clk); #1;
    check("post_resp_valid", resp_valid, 0);
    check("post_ready", req_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AB-1:0] a;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_state", debug_state, IDLE);
    check("rst_index", way_index, 0);
    check("rst_re", way_re, 0);
    check("rst_we", way_we, 0);
    check("rst_fill", way_fill, 0);
    check("rst_resp", {resp_valid, resp_hit, resp_way}, 0);
    check("rst_mem", {mem_req, mem_write, mem_addr}, 0);
    rst_n = 1'b1;

    // Read miss then read hit to 0x00040.
    do_req(1'b0, 20'h00040, 1, 1'b0);
    do_req(1'b0, 20'h00040, 0, 1'b0);

    // Fill set 5 with tags 1..4, hit tag 1, miss tag 9 -> PLRU victim way 2.
    for (int t = 1; t <= 4; t++) do_req(1'b0, {14'(t), 6'd5}, t - 1, 1'b0);
    do_req(1'b0, {14'd1, 6'd5}, 0, 1'b0);
    check("plru_victim_set5", m_victim(5), 2);
    do_req(1'b0, {14'd9, 6'd5}, 2, 1'b0);

    // Write hit to tag 2 set 5 (way 1), write miss to empty set 7, then read set 7 still misses.
    do_req(1'b1, {14'd2, 6'd5}, 1, 1'b0);
    do_req(1'b1, {14'd6, 6'd7}, 0, 1'b0);
    do_req(1'b0, {14'd6, 6'd7}, 0, 1'b0);

    // Reset while waiting for mem_ack.
    a = {14'd3, 6'd9};
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); #1;
    check("pre_rst_memreq", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_memreq", mem_req, 0);
    check("midrst_state", debug_state, IDLE);
    check("midrst_we", way_we, 0);
    check("midrst_ready", req_ready, 1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, a, 1, 1'b0);
    do_req(1'b0, 20'h00040, 0, 1'b0);

    // Held req_valid through a miss, then a stray ack while idle.
    a = {14'd11, 6'd2};
    do_req(1'b0, a, 2, 1'b1);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("stray_ack_we", way_we, 0);
    check("stray_ack_memreq", mem_req, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_ack_state", debug_state, IDLE);
    do_req(1'b0, a, 0, 1'b0);

    // Randomized traffic over a few sets and tags to exercise eviction.
    for (int i = 0; i < 60; i++) begin
      a = {14'($urandom_range(0, 6)), 6'($urandom_range(0, 3))};
      do_req(1'($urandom_range(0, 1)), a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
